// File: rtl/spi_host_master.sv
// SPI mode-0 host for the core's program/debug port.
// Accepts DATA_W-bit words on a valid/ready handshake, shifts them out MSB
// first on mosi_o while capturing miso_i, and returns the captured word with
// a one-cycle rx_valid_o pulse. tx_last_i=0 keeps CS low for the next word.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   tx_valid_i/tx_ready_o  word handshake; tx_data_i, tx_last_i latched on accept
//   rx_valid_o, rx_data_o  captured word, pulse + held data
//   busy_o                 high whenever the FSM is not idle
//   sclk_o, cs_o, mosi_o   SPI outputs (sclk idles low, cs active low)
//   miso_i                 SPI input, sampled on rising sclk
module spi_host_master #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_HP  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              cs_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int unsigned TMR_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);
  localparam int unsigned GAP_CYC = GAP_HP * CLK_DIV;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
  // tx shift register holds only the bits still to be sent after the MSB
  localparam int unsigned TXS_W   = DATA_W - 1;

  // Elaboration-time parameter guards
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_host_master: CLK_DIV must be >= 2");
  end
  if (DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
    $error("spi_host_master: DATA_W must be in 8..64");
  end
  if (GAP_HP < 1) begin : g_bad_gap_hp
    $error("spi_host_master: GAP_HP must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TXS_W-1:0]    tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;

  logic tick_c;
  logic accept_c;

  assign tick_c   = (tmr_q == TMR_W'(CLK_DIV - 1));
  assign accept_c = tx_valid_i && ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    tmr_d      = '0;
    bit_d      = bit_q;
    gap_d      = gap_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    last_d     = last_q;
    ready_d    = ready_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept_c) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = tx_data_i[DATA_W-1];
          tx_sr_d = tx_data_i[DATA_W-2:0];
          last_d  = tx_last_i;
          bit_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        tmr_d = tick_c ? '0 : tmr_q + TMR_W'(1);
        // First rising edge of the word: sample bit 0 of MISO
        if (tick_c) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
        end
      end

      ST_SHIFT: begin
        tmr_d = tick_c ? '0 : tmr_q + TMR_W'(1);
        if (tick_c) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
          end else begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sr_q[TXS_W-1];
            tx_sr_d = {tx_sr_q[TXS_W-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_d      = '0;
              tmr_d      = '0;
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
              if (last_q) begin
                state_d = ST_GAP;
              end else begin
                state_d = ST_HOLD;
                ready_d = 1'b1;
              end
            end
          end
        end
      end

      ST_GAP: begin
        // CS rises one cycle after the final falling SCLK edge so the
        // target sees the last edge before deselect.
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (gap_q == GAP_W'(GAP_CYC)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready_o = ready_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = busy_q;
  assign sclk_o     = sclk_q;
  assign cs_o       = cs_q;
  assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: a 32-bit/div-4 instance and an 8-bit/div-2
// instance, each driven against a behavioural SPI mode-0 target.
module tb_spi_host_master;

  localparam int W   = 32;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          tx_valid, tx_ready, tx_last, rx_valid, busy, sclk, cs, mosi;
  logic          miso = 1'b0;
  logic [W-1:0]  tx_data, rx_data;

  logic          tx_valid8, tx_ready8, tx_last8, rx_valid8, busy8, sclk8, cs8, mosi8;
  logic          miso8 = 1'b0;
  logic [7:0]    tx_data8, rx_data8;

  spi_host_master #(.DATA_W(32), .CLK_DIV(4), .GAP_HP(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data), .tx_last_i(tx_last),
    .rx_valid_o(rx_valid), .rx_data_o(rx_data), .busy_o(busy),
    .sclk_o(sclk), .cs_o(cs), .mosi_o(mosi), .miso_i(miso)
  );

  spi_host_master #(.DATA_W(8), .CLK_DIV(2), .GAP_HP(1)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_valid_i(tx_valid8), .tx_ready_o(tx_ready8), .tx_data_i(tx_data8), .tx_last_i(tx_last8),
    .rx_valid_o(rx_valid8), .rx_data_o(rx_data8), .busy_o(busy8),
    .sclk_o(sclk8), .cs_o(cs8), .mosi_o(mosi8), .miso_i(miso8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Cycle counter and accept tracking (sampled at the active edge)
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, acc_cyc8 = 0, acc_cnt8 = 0;
  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (tx_valid8 && tx_ready8) begin acc_cnt8++; acc_cyc8 = cyc; end
  end

  // Reference model state: what the target returns and what we expect back
  logic [W-1:0] s_q[$];
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] rxd_q[$];
  int rise_rel[$];
  int fall_rel[$];
  int s_bits = 0, rises_low = 0, cs_rises = 0, stab_err = 0, rx_cnt = 0, rxv_rel = -1;
  logic [W-1:0] acc_w = '0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, last_mosi = 1'b0;

  // Mode-0 target for the 32-bit instance, observed mid-cycle
  always @(negedge clk) begin
    int rel;
    rel = cyc - acc_cyc + 1;
    if (rx_valid) begin rxd_q.push_back(rx_data); rx_cnt++; rxv_rel = rel; end
    if (cs && !prev_cs) cs_rises++;
    if (cs) begin
      s_bits = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        acc_w = {acc_w[W-2:0], mosi};
        s_bits++;
        rises_low++;
        rise_rel.push_back(rel);
      end
      if (!sclk && prev_sclk) begin
        fall_rel.push_back(rel);
        last_mosi = mosi;
        if (s_bits == W) begin
          got_q.push_back(acc_w);
          if (s_q.size() > 0) void'(s_q.pop_front());
          s_bits = 0;
        end
      end else if (rel == 1) begin
        last_mosi = mosi;
      end else if (mosi !== last_mosi) begin
        stab_err++;
      end
    end
    if (!sclk) miso = (s_q.size() > 0 && s_bits < W) ? s_q[0][W-1-s_bits] : 1'b0;
    prev_sclk = sclk;
    prev_cs   = cs;
  end

  // Mode-0 target for the 8-bit instance
  logic [7:0] s8 = '0, got8 = '0, rxd8 = '0, a8 = '0;
  int b8 = 0, rises8 = 0, rxv_rel8 = -1;
  logic p8 = 1'b0;
  always @(negedge clk) begin
    if (rx_valid8) begin rxd8 = rx_data8; rxv_rel8 = cyc - acc_cyc8 + 1; end
    if (cs8) begin
      b8 = 0;
    end else begin
      if (sclk8 && !p8) begin a8 = {a8[6:0], mosi8}; b8++; rises8++; end
      if (!sclk8 && p8 && b8 == 8) begin got8 = a8; b8 = 0; end
    end
    if (!sclk8) miso8 = (b8 < 8) ? s8[7-b8] : 1'b0;
    p8 = sclk8;
  end

  task automatic send(input logic [W-1:0] d, input logic l, input logic [W-1:0] sw, input bit hold);
    int a0;
    a0 = acc_cnt;
    s_q.push_back(sw);
    exp_tx.push_back(d);
    exp_rx.push_back(sw);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_cnt == a0; i++) @(negedge clk);
    if (acc_cnt == a0) check("accept_timeout", 64'(acc_cnt), 64'(a0 + 1));
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_ready && !busy) break;
    end
    if (i == 5000) check({name, "_idle_timeout"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_rx(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_valid) break;
    end
    if (i == 2000) check({name, "_rx_timeout"}, 64'(rx_valid), 64'(1));
  endtask

  // Compare captured MOSI words and returned rx words against the model
  task automatic drain_check(input string name);
    check({name, "_n_mosi"}, 64'(got_q.size()), 64'(exp_tx.size()));
    check({name, "_n_rx"}, 64'(rxd_q.size()), 64'(exp_rx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_q.size(); i++)
      check($sformatf("%s_mosi%0d", name, i), 64'(got_q[i]), 64'(exp_tx[i]));
    for (int i = 0; i < exp_rx.size() && i < rxd_q.size(); i++)
      check($sformatf("%s_rx%0d", name, i), 64'(rxd_q[i]), 64'(exp_rx[i]));
    got_q.delete(); rxd_q.delete(); exp_tx.delete(); exp_rx.delete(); s_q.delete();
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic         last;
    logic [W-1:0] mi;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int r0, c0, x0, a0, rel, cs_up, rdy, cs_gl, mism, viol, seen, nlast;
    logic p;
    logic [W-1:0] d, m;
    logic l;

    tbl[0] = '{32'h0000_0001, 1'b0, 32'hDEAD_BEEF};
    tbl[1] = '{32'hFFFF_FFFE, 1'b0, 32'h8000_0000};
    tbl[2] = '{32'h1357_9BDF, 1'b1, 32'h0000_0001};
    tbl[3] = '{32'h8000_0000, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{32'h0F0F_F0F0, 1'b1, 32'h0000_0000};

    rst_n = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
    tx_valid8 = 1'b0; tx_last8 = 1'b0; tx_data8 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 64'(tx_ready), 64'(1));
    check("rst_rx_valid", 64'(rx_valid), 64'(0));
    check("rst_rx_data", 64'(rx_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sclk", 64'(sclk), 64'(0));
    check("rst_cs", 64'(cs), 64'(1));
    check("rst_mosi", 64'(mosi), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word with exact timing
    rise_rel.delete(); fall_rel.delete();
    send(32'hA5C3_0F81, 1'b1, 32'h1234_5678, 1'b0);
    check("t1_cs_low_c1", 64'(cs), 64'(0));
    check("t1_mosi_msb_c1", 64'(mosi), 64'(1));
    cs_up = -1; rdy = -1; cs_gl = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rel = cyc - acc_cyc + 1;
      if (cs && cs_up < 0) cs_up = rel;
      if (cs_up >= 0 && !cs) cs_gl++;
      if (tx_ready) begin rdy = rel; break; end
    end
    check("t1_rx_valid_cycle", 64'(rxv_rel), 64'(257));
    check("t1_cs_high_cycle", 64'(cs_up), 64'(258));
    check("t1_cs_glitch", 64'(cs_gl), 64'(0));
    check("t1_ready_cycle", 64'(rdy), 64'(258 + 8));
    check("t1_n_rises", 64'(rise_rel.size()), 64'(32));
    mism = 0;
    for (int k = 0; k < rise_rel.size() && k < 32; k++)
      if (rise_rel[k] != 1 + DIV * (2 * k + 1)) mism++;
    for (int k = 0; k < fall_rel.size() && k < 32; k++)
      if (fall_rel[k] != 1 + DIV * (2 * k + 2)) mism++;
    check("t1_edge_times", 64'(mism), 64'(0));
    check("t1_n_falls", 64'(fall_rel.size()), 64'(32));
    drain_check("t1");

    // Table-driven: 3-word burst, then two single words
    r0 = rises_low; c0 = cs_rises; x0 = rx_cnt;
    for (int i = 0; i < 3; i++) send(tbl[i].tx, tbl[i].last, tbl[i].mi, 1'b0);
    wait_idle("burst");
    check("burst_rises", 64'(rises_low - r0), 64'(96));
    check("burst_cs_rises", 64'(cs_rises - c0), 64'(1));
    check("burst_rx_pulses", 64'(rx_cnt - x0), 64'(3));
    for (int i = 3; i < 5; i++) begin
      send(tbl[i].tx, tbl[i].last, tbl[i].mi, 1'b0);
      wait_idle("single");
    end
    drain_check("tbl");

    // HOLD stall for 50 cycles, then resume without CS glitch
    c0 = cs_rises;
    send(32'hCAFE_0001, 1'b0, 32'h5A5A_A5A5, 1'b0);
    wait_rx("hold");
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs || sclk || !tx_ready) viol++;
    end
    check("hold_stall_viol", 64'(viol), 64'(0));
    send(32'hCAFE_0002, 1'b1, 32'h0102_0304, 1'b0);
    wait_idle("hold");
    check("hold_cs_rises", 64'(cs_rises - c0), 64'(1));
    drain_check("hold");

    // Reset at bit 10 of a word
    x0 = rx_cnt;
    send(32'h7777_1111, 1'b1, 32'h3333_CCCC, 1'b0);
    seen = 0; p = sclk;
    for (int i = 0; i < 500 && seen < 11; i++) begin
      @(negedge clk);
      if (sclk && !p) seen++;
      p = sclk;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", 64'(cs), 64'(1));
    check("rst_mid_sclk", 64'(sclk), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(tx_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_rx", 64'(rx_cnt - x0), 64'(0));
    check("rst_mid_rx_data", 64'(rx_data), 64'(0));
    got_q.delete(); rxd_q.delete(); exp_tx.delete(); exp_rx.delete(); s_q.delete();
    send(32'hBEEF_4321, 1'b1, 32'h9876_5432, 1'b0);
    wait_idle("post_rst");
    drain_check("post_rst");

    // tx_valid held high through the whole word: exactly one accept
    a0 = acc_cnt;
    send(32'h0123_4567, 1'b1, 32'hFEDC_BA98, 1'b1);
    wait_rx("held");
    tx_valid = 1'b0;
    check("held_accepts", 64'(acc_cnt - a0), 64'(1));
    wait_idle("held");
    drain_check("held");

    // Randomized traffic against the model
    r0 = rises_low; c0 = cs_rises; x0 = rx_cnt; nlast = 0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      m = $urandom;
      l = (i == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      if (l) nlast++;
      send(d, l, m, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand");
    check("rand_rises", 64'(rises_low - r0), 64'(16 * 32));
    check("rand_cs_rises", 64'(cs_rises - c0), 64'(nlast));
    check("rand_rx_pulses", 64'(rx_cnt - x0), 64'(16));
    drain_check("rand");

    // 8-bit / divide-by-2 instance
    s8 = 8'h7E;
    a0 = acc_cnt8;
    tx_data8 = 8'h81; tx_last8 = 1'b1; tx_valid8 = 1'b1;
    for (int i = 0; i < 200 && acc_cnt8 == a0; i++) @(negedge clk);
    if (acc_cnt8 == a0) check("w8_accept_timeout", 64'(acc_cnt8), 64'(a0 + 1));
    tx_valid8 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready8 && !busy8) break;
    end
    check("w8_rx_data", 64'(rxd8), 64'(8'h7E));
    check("w8_mosi_word", 64'(got8), 64'(8'h81));
    check("w8_rx_valid_cycle", 64'(rxv_rel8), 64'(33));
    check("w8_rises", 64'(rises8), 64'(8));

    check("mosi_stable_between_falls", 64'(stab_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
